// File: rtl/vcve2_dmem_arbiter_rr.sv
// rtl/vcve2_dmem_arbiter_rr.sv - N-way dmem arbiter (fixed/round-robin, lock, hold) with response-ID FIFO
// Optional per-requestor grant counters and stall flag when VCVE2_DMEM_ARB_PERF_EN is defined.
module vcve2_dmem_arbiter_rr #(
  parameter int unsigned NReq           = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NReq-1:0]         req_i,
  input  logic [NReq-1:0]         we_i,
  input  logic [NReq*4-1:0]       be_i,
  input  logic [NReq*32-1:0]      addr_i,
  input  logic [NReq*32-1:0]      wdata_i,
  output logic [NReq-1:0]         gnt_o,
  output logic [NReq-1:0]         rvalid_o,
  output logic [NReq-1:0]         err_o,
  output logic [31:0]             rdata_o,
  input  logic                    lock_i,
  input  logic [$clog2(NReq)-1:0] lock_id_i,
  output logic                    data_req_o,
  output logic                    data_we_o,
  output logic [3:0]              data_be_o,
  output logic [31:0]             data_addr_o,
  output logic [31:0]             data_wdata_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic                    data_err_i,
  input  logic [31:0]             data_rdata_i,
`ifdef VCVE2_DMEM_ARB_PERF_EN
  output logic [NReq*16-1:0]      perf_gnt_cnt_o,
  output logic                    perf_stall_o,
`endif
  output logic                    busy_o
);
  localparam int unsigned IdW  = $clog2(NReq);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]  rr_q, rr_d, hold_id_q, hold_id_d;
  logic            hold_q, hold_d;
  logic [IdW-1:0]  fifo_q [MaxOutstanding];
  logic [IdW-1:0]  fifo_d [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NReq-1:0] lock_mask, eligible;
  logic [IdW-1:0]  winner, head;
  logic            any_elig, full, empty, gnt, pop, found;
  int unsigned     idx;

  // A stalled winner keeps its slot until granted, unless it withdraws or lock overrides.
  always_comb begin
    lock_mask = NReq'(1) << lock_id_i;
    eligible  = lock_i ? (lock_mask & req_i) : req_i;
    any_elig  = |eligible;
    winner    = '0;
    found     = 1'b0;
    idx       = 0;
    if (hold_q && !lock_i && req_i[hold_id_q]) begin
      winner = hold_id_q;
    end else begin
      for (int unsigned i = 0; i < NReq; i++) begin
        idx = RoundRobin ? (32'(rr_q) + i) % NReq : i;
        if (!found && eligible[idx]) begin
          winner = IdW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];
  assign gnt   = data_gnt_i & data_req_o;
  assign pop   = data_rvalid_i & !empty;

  assign data_req_o   = any_elig & !full;
  assign data_we_o    = data_req_o & we_i[winner];
  assign data_be_o    = data_req_o ? be_i[4*winner +: 4] : 4'h0;
  assign data_addr_o  = data_req_o ? addr_i[32*winner +: 32] : 32'h0;
  assign data_wdata_o = data_req_o ? wdata_i[32*winner +: 32] : 32'h0;

  assign gnt_o    = gnt ? (NReq'(1) << winner) : '0;
  assign rvalid_o = pop ? (NReq'(1) << head) : '0;
  assign err_o    = (pop && data_err_i) ? (NReq'(1) << head) : '0;
  assign rdata_o  = data_rdata_i;
  assign busy_o   = !empty;

  always_comb begin
    rr_d      = rr_q;
    hold_d    = 1'b0;
    hold_id_d = hold_id_q;
    fifo_d    = fifo_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q + CntW'(gnt) - CntW'(pop);
    if (gnt) begin
      rr_d           = (winner == IdW'(NReq - 1)) ? '0 : winner + 1'b1;
      fifo_d[wptr_q] = winner;
      wptr_d         = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (data_req_o && !data_gnt_i) begin
      hold_d    = 1'b1;
      hold_id_d = winner;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      hold_q    <= 1'b0;
      hold_id_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      fifo_q    <= fifo_d;
    end
  end

`ifdef VCVE2_DMEM_ARB_PERF_EN
  logic [15:0] perf_cnt_q [NReq];
  logic [15:0] perf_cnt_d [NReq];

  always_comb begin
    perf_gnt_cnt_o = '0;
    for (int unsigned k = 0; k < NReq; k++) begin
      perf_cnt_d[k] = perf_cnt_q[k];
      if (gnt_o[k] && perf_cnt_q[k] != 16'hFFFF) perf_cnt_d[k] = perf_cnt_q[k] + 16'd1;
      perf_gnt_cnt_o[16*k +: 16] = perf_cnt_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NReq; k++) perf_cnt_q[k] <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_stall_o = (|req_i) & !data_req_o;
`endif

  always @(posedge clk_i) begin
    if (rst_ni && data_rvalid_i) begin
      assert (cnt_q != '0) else $warning("data_rvalid_i with no outstanding transaction");
    end
  end
endmodule

// File: tb/tb_vcve2_dmem_arbiter_rr.sv
// tb/tb_vcve2_dmem_arbiter_rr.sv - scoreboard bench for vcve2_dmem_arbiter_rr (RR and fixed-priority instances)
module tb_vcve2_dmem_arbiter_rr;
  localparam logic [31:0] AddrA = 32'hA000_0040;
  localparam logic [31:0] AddrB = 32'hB000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we;
  logic [7:0]  be;
  logic [63:0] addr, wdata;
  logic        lock, lock_id;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;

  logic [1:0]  gnt_rr, rvalid_rr, err_rr, gnt_fix, rvalid_fix, err_fix;
  logic [31:0] rdata_rr, rdata_fix, addr_rr, addr_fix, wdata_rr, wdata_fix;
  logic [3:0]  be_rr, be_fix;
  logic        data_req_rr, data_req_fix, we_rr, we_fix, busy_rr, busy_fix;

  int checks = 0;
  int errors = 0;
  bit mon_rr, mon_fix;
  logic [33:0] exp_gnt_q [$];
  logic [35:0] exp_rsp_q [$];
  logic [1:0]  exp_fgnt_q [$];

  always #5 clk = ~clk;

  vcve2_dmem_arbiter_rr #(.NReq(2), .MaxOutstanding(2), .RoundRobin(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_rr), .rvalid_o(rvalid_rr), .err_o(err_rr), .rdata_o(rdata_rr),
    .lock_i(lock), .lock_id_i(lock_id),
    .data_req_o(data_req_rr), .data_we_o(we_rr), .data_be_o(be_rr), .data_addr_o(addr_rr),
    .data_wdata_o(wdata_rr), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_err_i(data_err),
    .data_rdata_i(data_rdata), .busy_o(busy_rr)
  );

  vcve2_dmem_arbiter_rr #(.NReq(2), .MaxOutstanding(2), .RoundRobin(1'b0)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_fix), .rvalid_o(rvalid_fix), .err_o(err_fix), .rdata_o(rdata_fix),
    .lock_i(lock), .lock_id_i(lock_id),
    .data_req_o(data_req_fix), .data_we_o(we_fix), .data_be_o(be_fix), .data_addr_o(addr_fix),
    .data_wdata_o(wdata_fix), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_err_i(data_err),
    .data_rdata_i(data_rdata), .busy_o(busy_fix)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set(input logic [1:0] r, input logic g, input logic rv, input logic e, input logic [31:0] rd);
    req = r; data_gnt = g; data_rvalid = rv; data_err = e; data_rdata = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input logic [1:0] g, input logic [31:0] a);
    exp_gnt_q.push_back({g, a});
  endtask

  task automatic push_r(input logic [1:0] rv, input logic [1:0] e, input logic [31:0] d);
    exp_rsp_q.push_back({rv, e, d});
  endtask

  task automatic do_reset();
    set(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt_rr, 0);
    chk("rst_rvalid", rvalid_rr, 0);
    chk("rst_data_req", data_req_rr, 0);
    chk("rst_busy", busy_rr, 0);
    chk("rst_busy_fix", busy_fix, 0);
    chk("rst_addr", addr_rr, 0);
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_rr) begin
      if (gnt_rr != 2'b00) begin
        if (exp_gnt_q.size() == 0) chk("gnt_unexpected", gnt_rr, 0);
        else chk("gnt_addr", {gnt_rr, addr_rr}, exp_gnt_q.pop_front());
      end
      if (rvalid_rr != 2'b00) begin
        if (exp_rsp_q.size() == 0) chk("rvalid_unexpected", rvalid_rr, 0);
        else chk("rsp_rv_err_data", {rvalid_rr, err_rr, rdata_rr}, exp_rsp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_fix && gnt_fix != 2'b00) begin
      if (exp_fgnt_q.size() == 0) chk("fix_gnt_unexpected", gnt_fix, 0);
      else chk("fix_gnt", gnt_fix, exp_fgnt_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    addr = {AddrB, AddrA}; wdata = {32'h2222_2222, 32'h1111_1111};
    be = {4'hC, 4'h3}; we = 2'b10; lock = 1'b0; lock_id = 1'b0;
    mon_rr = 1'b1; mon_fix = 1'b0;
    do_reset();

    // round-robin alternation, responses one cycle behind
    set(2'b11, 1, 0, 0, 32'h0);  push_g(2'b01, AddrA); tick();
    set(2'b11, 1, 1, 0, 32'h11); push_g(2'b10, AddrB); push_r(2'b01, 2'b00, 32'h11); tick();
    set(2'b11, 1, 1, 0, 32'h22); push_g(2'b01, AddrA); push_r(2'b10, 2'b00, 32'h22); tick();
    set(2'b11, 1, 1, 0, 32'h33); push_g(2'b10, AddrB); push_r(2'b01, 2'b00, 32'h33); tick();
    set(2'b00, 0, 1, 0, 32'h44); push_r(2'b10, 2'b00, 32'h44); tick();

    // fixed priority instance
    do_reset();
    mon_rr = 1'b0; mon_fix = 1'b1;
    set(2'b11, 1, 0, 0, 32'h0); exp_fgnt_q.push_back(2'b01); tick();
    set(2'b11, 1, 1, 0, 32'h0); exp_fgnt_q.push_back(2'b01); tick();
    set(2'b10, 1, 1, 0, 32'h0); exp_fgnt_q.push_back(2'b10); tick();
    set(2'b00, 0, 1, 0, 32'h0); tick();
    chk("fix_busy_drained", busy_fix, 0);

    // hold: stalled requestor 1 keeps the port when requestor 0 arrives
    do_reset();
    mon_rr = 1'b1; mon_fix = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set(2'b10, 0, 0, 0, 32'h0);
      chk("hold_addr", addr_rr, AddrB);
      tick();
    end
    set(2'b11, 0, 0, 0, 32'h0);
    chk("hold_keep_addr", addr_rr, AddrB);
    chk("hold_keep_be", be_rr, 4'hC);
    chk("hold_keep_we", we_rr, 1);
    chk("fix_hold_keep_addr", addr_fix, AddrB);
    tick();
    set(2'b11, 1, 0, 0, 32'h0);  push_g(2'b10, AddrB); tick();
    set(2'b11, 1, 0, 0, 32'h0);  push_g(2'b01, AddrA); tick();
    set(2'b00, 0, 1, 0, 32'h55); push_r(2'b10, 2'b00, 32'h55); tick();
    set(2'b00, 0, 1, 0, 32'h66); push_r(2'b01, 2'b00, 32'h66); tick();

    // outstanding limit: full blocks requests, frees one cycle after rvalid
    set(2'b11, 1, 0, 0, 32'h0);  push_g(2'b10, AddrB); tick();
    set(2'b11, 1, 0, 0, 32'h0);  push_g(2'b01, AddrA); tick();
    set(2'b11, 1, 0, 0, 32'h0);
    chk("full_data_req", data_req_rr, 0);
    chk("full_busy", busy_rr, 1);
    tick();
    set(2'b11, 1, 1, 0, 32'h77); push_r(2'b10, 2'b00, 32'h77);
    chk("full_no_rvalid_path", data_req_rr, 0);
    tick();
    set(2'b11, 0, 0, 0, 32'h0);
    chk("full_reopen", data_req_rr, 1);
    chk("full_reopen_addr", addr_rr, AddrB);
    tick();
    set(2'b00, 0, 1, 0, 32'h88); push_r(2'b01, 2'b00, 32'h88); tick();

    // lock to requestor 1, error response
    do_reset();
    lock = 1'b1; lock_id = 1'b1;
    set(2'b11, 1, 0, 0, 32'h0);  push_g(2'b10, AddrB); tick();
    set(2'b11, 1, 1, 1, 32'h99); push_g(2'b10, AddrB); push_r(2'b10, 2'b10, 32'h99); tick();
    lock = 1'b0;
    set(2'b00, 0, 1, 0, 32'hAA); push_r(2'b10, 2'b00, 32'hAA); tick();

    // spurious response, then reset with two outstanding
    chk("spur_busy", busy_rr, 0);
    set(2'b00, 0, 1, 0, 32'hBB);
    chk("spur_rvalid", rvalid_rr, 0);
    tick();
    set(2'b11, 1, 0, 0, 32'h0); push_g(2'b01, AddrA); tick();
    set(2'b11, 1, 0, 0, 32'h0); push_g(2'b10, AddrB); tick();
    set(2'b00, 0, 0, 0, 32'h0);
    chk("mid_busy", busy_rr, 1);
    do_reset();
    set(2'b00, 0, 1, 0, 32'hCC);
    chk("post_rst_rvalid", rvalid_rr, 0);
    tick();
    set(2'b00, 0, 0, 0, 32'h0);
    tick();

    chk("gnt_queue_empty", exp_gnt_q.size(), 0);
    chk("rsp_queue_empty", exp_rsp_q.size(), 0);
    chk("fix_queue_empty", exp_fgnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
